rv32i_mem_arbiter: RTL and testbench

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/rv32i_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// ============================================================================
// Module   : rv32i_mem_arbiter
// Purpose  : Two-master (MEM stage / debug) arbiter for a single-port data RAM
//            with one-cycle read latency and bounded debug starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // MEM-stage requester
  input  logic        m_req,
  input  logic        m_we,
  input  logic [3:0]  m_be,
  input  logic [29:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_gnt,
  output logic        m_rvalid,
  output logic        m_stall,
  // debug / loader requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  // shared read return
  output logic [31:0] rdata,
  // RAM data port
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);
  localparam logic       C_OWN_M = 1'b0;
  localparam logic       C_OWN_D = 1'b1;

  state_t      state_q;
  logic        owner_q;
  logic [3:0]  starve_cnt_q;
  logic        rst_sync_q;

  logic        w_idle;
  logic        w_rd_wait;
  logic        w_m_win;
  logic        w_d_win;
  logic        w_m_owns_rd;

  // Release of reset is retimed to clk; assertion still clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  assign w_idle      = rst_sync_q && (state_q == ST_IDLE);
  assign w_rd_wait   = rst_sync_q && (state_q == ST_RD_WAIT);
  assign w_m_win     = w_idle && m_req && (!d_req || (starve_cnt_q < C_LIMIT));
  assign w_d_win     = w_idle && d_req && !w_m_win;
  assign w_m_owns_rd = w_rd_wait && (owner_q == C_OWN_M);

  always_comb begin
    m_gnt     = w_m_win;
    d_gnt     = w_d_win;
    ram_en    = w_m_win | w_d_win;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = 30'd0;
    ram_wdata = 32'd0;
    if (w_m_win) begin
      ram_we    = m_we;
      ram_be    = m_we ? m_be : 4'h0;
      ram_addr  = m_addr;
      ram_wdata = m_wdata;
    end else if (w_d_win) begin
      ram_we    = d_we;
      ram_be    = d_we ? 4'hF : 4'h0;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end
  end

  assign m_rvalid = w_m_owns_rd;
  assign d_rvalid = w_rd_wait && (owner_q == C_OWN_D);
  assign rdata    = w_rd_wait ? ram_rdata : 32'd0;

  // The pipeline may advance in the cycle its own read data is returned.
  assign m_stall  = rst_sync_q && !w_m_owns_rd &&
                    ((m_req && !w_m_win) || (w_m_win && !m_we));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= C_OWN_M;
      starve_cnt_q <= 4'd0;
    end else if (rst_sync_q) begin
      case (state_q)
        ST_IDLE: begin
          if (w_m_win && !m_we) begin
            state_q <= ST_RD_WAIT;
            owner_q <= C_OWN_M;
          end else if (w_d_win && !d_we) begin
            state_q <= ST_RD_WAIT;
            owner_q <= C_OWN_D;
          end
          if (w_d_win || !d_req) begin
            starve_cnt_q <= 4'd0;
          end else if (w_m_win && (starve_cnt_q < C_LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
          end
        end
        ST_RD_WAIT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
// ============================================================================
// Module   : tb_rv32i_mem_arbiter
// Purpose  : Vector table plus read-return scoreboard for rv32i_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt, m_rvalid, m_stall;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_stall(m_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [0:63];
  logic [31:0] ram_rd_q;
  assign ram_rdata = ram_rd_q;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rd_q <= mem[ram_addr[5:0]];
      end
    end
  end

  typedef struct {
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic        d_req, d_we;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_mgnt, e_dgnt, e_stall;
  } vec_t;

  typedef struct {
    logic        own_d;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs [0:63];
  int          n_vec;
  sb_t         sb_q [$];
  logic [31:0] ref_mem [0:63];
  int          n_tests;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic mr, input logic mw, input logic [3:0] mbe,
                      input logic [29:0] ma, input logic [31:0] md,
                      input logic dr, input logic dw, input logic [29:0] da,
                      input logic [31:0] dd,
                      input logic emg, input logic edg, input logic est);
    vecs[n_vec] = '{mr, mw, mbe, ma, md, dr, dw, da, dd, emg, edg, est};
    n_vec++;
  endtask

  task automatic drive_idle();
    m_req = 1'b0; m_we = 1'b0; m_be = 4'h0; m_addr = '0; m_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    logic        e_en, e_we;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wdata;
    sb_t         s;
    string       tag;
    m_req = v.m_req; m_we = v.m_we; m_be = v.m_be; m_addr = v.m_addr; m_wdata = v.m_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #1;
    tag = $sformatf("v%0d", idx);
    e_en = v.e_mgnt | v.e_dgnt;
    e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_wdata = '0;
    if (v.e_mgnt) begin
      e_we = v.m_we; e_be = v.m_we ? v.m_be : 4'h0; e_addr = v.m_addr; e_wdata = v.m_wdata;
    end else if (v.e_dgnt) begin
      e_we = v.d_we; e_be = v.d_we ? 4'hF : 4'h0; e_addr = v.d_addr; e_wdata = v.d_wdata;
    end
    chk({tag, " m_gnt"},     32'(m_gnt),     32'(v.e_mgnt));
    chk({tag, " d_gnt"},     32'(d_gnt),     32'(v.e_dgnt));
    chk({tag, " m_stall"},   32'(m_stall),   32'(v.e_stall));
    chk({tag, " ram_en"},    32'(ram_en),    32'(e_en));
    chk({tag, " ram_we"},    32'(ram_we),    32'(e_we));
    chk({tag, " ram_be"},    32'(ram_be),    32'(e_be));
    chk({tag, " ram_addr"},  32'(ram_addr),  32'(e_addr));
    chk({tag, " ram_wdata"}, ram_wdata,      e_wdata);
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      chk({tag, " m_rvalid"}, 32'(m_rvalid), 32'(!s.own_d));
      chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(s.own_d));
      chk({tag, " rdata"},    rdata,         s.data);
    end else begin
      chk({tag, " m_rvalid"}, 32'(m_rvalid), 32'd0);
      chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'd0);
      chk({tag, " rdata"},    rdata,         32'd0);
    end
    if (v.e_mgnt || v.e_dgnt) begin
      if (e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[e_addr[5:0]][8*b +: 8] = e_wdata[8*b +: 8];
      end else begin
        s.own_d = v.e_dgnt;
        s.data  = ref_mem[e_addr[5:0]];
        sb_q.push_back(s);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_all();
    for (int i = 0; i < n_vec; i++) run_vec(vecs[i], i);
    n_vec = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_vec = 0;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    ram_rd_q = 32'd0;
    drive_idle();
    reset = 1'b0;
    m_req = 1'b1; d_req = 1'b1;
    #2;
    chk("rst m_gnt",  32'(m_gnt),  32'd0);
    chk("rst d_gnt",  32'(d_gnt),  32'd0);
    chk("rst ram_en", 32'(ram_en), 32'd0);
    chk("rst m_stall", 32'(m_stall), 32'd0);
    chk("rst rdata",  rdata,       32'd0);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Phase 1: basic transfers, read bubble, debug priority, write-then-read.
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    addv(1,1,4'h3,30'h10,32'hDEADBEEF,  0,0,30'h00,32'h0,         1,0,0);
    addv(1,0,4'h0,30'h10,32'h0,         0,0,30'h00,32'h0,         1,0,1);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    addv(0,0,4'h0,30'h00,32'h0,         1,1,30'h20,32'h12345678,  0,1,0);
    addv(0,0,4'h0,30'h00,32'h0,         1,0,30'h20,32'h0,         0,1,0);
    addv(1,0,4'h0,30'h10,32'h0,         0,0,30'h00,32'h0,         0,0,1);
    addv(1,0,4'h0,30'h10,32'h0,         0,0,30'h00,32'h0,         1,0,1);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    addv(1,1,4'hF,30'h30,32'hCAFEF00D,  0,0,30'h00,32'h0,         1,0,0);
    addv(1,0,4'h0,30'h30,32'h0,         0,0,30'h00,32'h0,         1,0,1);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    addv(1,0,4'h0,30'h30,32'h0,         1,0,30'h20,32'h0,         1,0,1);
    addv(0,0,4'h0,30'h00,32'h0,         1,0,30'h20,32'h0,         0,0,0);
    addv(0,0,4'h0,30'h00,32'h0,         1,0,30'h20,32'h0,         0,1,0);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    // Both requesters hammering writes: M four times, then D once, repeating.
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        addv(1,1,4'h5,30'h01,32'h11110000 + k, 1,1,30'h02,32'hD0000000 + k, 0,1,1);
      else
        addv(1,1,4'h5,30'h01,32'h11110000 + k, 1,1,30'h02,32'hD0000000 + k, 1,0,0);
    end
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    run_all();

    // Phase 2: build up starvation count, then reset in the middle of a read.
    addv(1,1,4'hF,30'h01,32'hAAAA0001,  1,1,30'h02,32'hBBBB0001,  1,0,0);
    addv(1,1,4'hF,30'h01,32'hAAAA0002,  1,1,30'h02,32'hBBBB0002,  1,0,0);
    addv(1,0,4'h0,30'h10,32'h0,         1,1,30'h02,32'hBBBB0003,  1,0,1);
    run_all();
    reset = 1'b0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 30'h10; d_req = 1'b1; d_we = 1'b0;
    #1;
    chk("midrst m_rvalid", 32'(m_rvalid), 32'd0);
    chk("midrst d_rvalid", 32'(d_rvalid), 32'd0);
    chk("midrst rdata",    rdata,         32'd0);
    chk("midrst m_gnt",    32'(m_gnt),    32'd0);
    chk("midrst d_gnt",    32'(d_gnt),    32'd0);
    chk("midrst ram_en",   32'(ram_en),   32'd0);
    chk("midrst m_stall",  32'(m_stall),  32'd0);
    sb_q.delete();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    chk("rel m_rvalid", 32'(m_rvalid), 32'd0);
    chk("rel d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk);

    // Starvation count must restart from zero after reset.
    for (int k = 0; k < 5; k++) begin
      if (k == 4)
        addv(1,1,4'hF,30'h03,32'h33330000 + k, 1,1,30'h04,32'h44440000 + k, 0,1,1);
      else
        addv(1,1,4'hF,30'h03,32'h33330000 + k, 1,1,30'h04,32'h44440000 + k, 1,0,0);
    end
    addv(0,0,4'h0,30'h00,32'h0,         1,0,30'h04,32'h0,         0,1,0);
    addv(0,0,4'h0,30'h00,32'h0,         0,0,30'h00,32'h0,         0,0,0);
    run_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
